// File: rtl/tb_checker_pkg.sv
// tb_checker_pkg: shared state encoding and default counter width for the output checker
package tb_checker_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/tb_output_checker_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its all-ones value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (inc && q != {W{1'b1}}) q <= q + 1'b1;
endmodule

// File: rtl/tb_output_checker.sv
// tb_output_checker: compares DUT and reference samples, counts mismatches, captures the first one.
// Define CHECKER_XCHECK_EN to make X/Z differences in dut_val count as mismatches.
module tb_output_checker
  import tb_checker_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             sample_last,
  input  logic [WIDTH-1:0] dut_val,
  input  logic [WIDTH-1:0] ref_val,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_vld,
  output logic [CNT_W-1:0] first_idx,
  output logic [WIDTH-1:0] first_dut,
  output logic [WIDTH-1:0] first_ref
);
  state_t state, state_n;
  logic mis, acc;
`ifdef CHECKER_XCHECK_EN
  assign mis = dut_val !== ref_val;
`else
  // an unknown inequality result falls to the else branch and is not counted
  always_comb begin
    mis = 1'b0;
    if (dut_val != ref_val) mis = 1'b1;
  end
`endif
  assign acc = state == RUN && sample_valid && !start;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb
    state_n = start ? RUN : (acc && sample_last) ? DONE : state;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(acc), .q(sample_cnt)
  );
  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk(clk), .reset(reset), .clr(start), .inc(acc && mis), .q(mismatch_cnt)
  );
  always_ff @(posedge clk)
    if (reset || start) begin
      first_vld <= 1'b0;
      first_idx <= '0;
      first_dut <= '0;
      first_ref <= '0;
      pass      <= 1'b0;
    end else if (acc) begin
      if (mis && !first_vld) begin
        first_vld <= 1'b1;
        first_idx <= sample_cnt;
        first_dut <= dut_val;
        first_ref <= ref_val;
      end
      if (sample_last) pass <= !mis && mismatch_cnt == '0;
    end
endmodule
